afrc_tex_arbiter: RTL

Shares the single-outstanding AFRC compressed-texture decode unit among NREQ texture requesters (TMU quads). Round-robin arbitration picks one request and issues it to the decode unit. It captures the decoded 512-bit block into a local response register and returns it to the owning requester. A watchdog aborts transactions the decode unit never completes.

---
 rtl/afrc_pkg.sv | 17 +
 rtl/afrc_tex_arbiter_rr_arbiter.sv | 38 +++
 rtl/afrc_tex_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/afrc_pkg.sv
// Shared definitions for the AFRC texture-decode arbiter.
//   arb_state_t  : transaction FSM states
//   AFRC_ADDR_W  : default compressed-block address width
//   AFRC_DATA_W  : default decoded texel block width
package afrc_pkg;

    localparam int unsigned AFRC_ADDR_W = 64;
    localparam int unsigned AFRC_DATA_W = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/afrc_tex_arbiter_rr_arbiter.sv
// Combinational round-robin picker: grants the first asserted request at or
// after ptr, wrapping around.
//   req     : request vector
//   ptr     : highest-priority index this round
//   gnt     : one-hot grant (all-zero when no request)
//   gnt_idx : binary index of the granted request
module rr_arbiter
    import afrc_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    int unsigned idx;
    logic        found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!found && req[IW'(idx)]) begin
                gnt[IW'(idx)] = 1'b1;
                gnt_idx       = IW'(idx);
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/afrc_tex_arbiter.sv
// Shares a single-outstanding AFRC decode unit among NREQ texture requesters.
//   rq_valid/rq_addr/rq_ready : per-requester fetch request (one-hot accept)
//   rs_valid/rs_data/rs_err/rs_ready : response to owning requester
//   tu_req_*  : issue channel to the decode unit
//   tu_tex_*  : decoded block return channel from the decode unit
//   busy      : a transaction is in progress
//   timeout_err : sticky flag, set on any watchdog abort
module afrc_tex_arbiter
    import afrc_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned ADDR_W  = AFRC_ADDR_W,
    parameter int unsigned DATA_W  = AFRC_DATA_W,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        rq_valid,
    input  logic [NREQ*ADDR_W-1:0] rq_addr,
    output logic [NREQ-1:0]        rq_ready,
    output logic [NREQ-1:0]        rs_valid,
    output logic [DATA_W-1:0]      rs_data,
    output logic                   rs_err,
    input  logic [NREQ-1:0]        rs_ready,
    output logic                   tu_req_valid,
    output logic [ADDR_W-1:0]      tu_req_addr,
    input  logic                   tu_req_ready,
    input  logic                   tu_tex_valid,
    input  logic [DATA_W-1:0]      tu_tex_data,
    output logic                   tu_tex_ready,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT);

    arb_state_t          state, state_nxt;
    logic [IW-1:0]       ptr, owner, gnt_idx;
    logic [NREQ-1:0]     gnt;
    logic [ADDR_W-1:0]   addr_q, addr_sel;
    logic [DATA_W-1:0]   data_q;
    logic                err_q, tout_q;
    logic [WW-1:0]       wd;
    logic                wd_expired;

    rr_arbiter #(.N(NREQ)) u_rr (
        .req     (rq_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        addr_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx == IW'(i)) addr_sel = rq_addr[i*ADDR_W +: ADDR_W];
        end
    end

    assign wd_expired = (wd == WD_MAX);

    always_comb begin
        state_nxt    = state;
        rq_ready     = '0;
        rs_valid     = '0;
        tu_req_valid = 1'b0;
        tu_tex_ready = 1'b0;
        case (state)
            IDLE: begin
                if (|rq_valid) begin
                    rq_ready  = gnt;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // Issue is withdrawn on the expiry cycle so the decode unit
                // never accepts a request that is already being aborted.
                if (wd_expired) begin
                    state_nxt = RESP;
                end else begin
                    tu_req_valid = 1'b1;
                    if (tu_req_ready) state_nxt = WAIT;
                end
            end
            WAIT: begin
                tu_tex_ready = 1'b1;
                if (tu_tex_valid || wd_expired) state_nxt = RESP;
            end
            RESP: begin
                rs_valid[owner] = 1'b1;
                if (rs_ready[owner]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            owner  <= '0;
            addr_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            tout_q <= 1'b0;
            wd     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (|rq_valid) begin
                        owner  <= gnt_idx;
                        addr_q <= addr_sel;
                        wd     <= '0;
                    end
                end
                ISSUE, WAIT: begin
                    // A block arriving on the expiry cycle is still delivered.
                    if (state == WAIT && tu_tex_valid) begin
                        data_q <= tu_tex_data;
                        err_q  <= 1'b0;
                    end else if (wd_expired) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                        tout_q <= 1'b1;
                    end else begin
                        wd <= wd + WW'(1);
                    end
                end
                RESP: begin
                    if (rs_ready[owner])
                        ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
                end
                default: ;
            endcase
        end
    end

    assign rs_data     = data_q;
    assign rs_err      = err_q;
    assign tu_req_addr = addr_q;
    assign busy        = (state != IDLE);
    assign timeout_err = tout_q;

endmodule
